// File: rtl/mul32_share_arb_if.sv
// Request/response bundle between compute clients and the shared 32x32 multiplier sequencer.
// The master side is the client population; the slave side is the arbiter.
`timescale 1ns/1ps
interface mul32_share_arb_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [63:0]          rsp_p;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
  );
endinterface

// File: rtl/mul32_share_arb.sv
// Round-robin arbiter that time-shares one 32x32 unsigned multiplier among NREQ clients.
// Operands are registered on accept; the product is taken MUL_LAT cycles later (multicycle path).
`timescale 1ns/1ps
module mul32_share_arb #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mul32_share_arb_if.slave  bus
);

  localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_op_a;
  logic [31:0]       r_op_b;
  logic              r_rsp_valid;
  logic [63:0]       r_rsp_p;
  logic [ID_W-1:0]   r_rsp_id;

  logic              w_hi_found;
  logic              w_lo_found;
  logic [ID_W-1:0]   w_hi_idx;
  logic [ID_W-1:0]   w_lo_idx;
  logic              w_win_found;
  logic [ID_W-1:0]   w_win_idx;
  logic [31:0]       w_sel_a;
  logic [31:0]       w_sel_b;
  logic              w_accept;
  logic [63:0]       w_product;

  // Round robin: lowest valid index above last_grant wins, else lowest valid index overall.
  // The descending scan lets the final write in each group be the lowest index.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (ID_W'(i) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = ID_W'(i);
        end
      end
    end
    w_win_found = w_hi_found | w_lo_found;
    w_win_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_idx == ID_W'(i)) begin
        w_sel_a = bus.req_a[32*i +: 32];
        w_sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  assign w_accept      = (r_state == S_IDLE) && w_win_found && !rst;
  assign bus.req_ready = w_accept ? (NREQ'(1) << w_win_idx) : '0;

  // Fed only from the operand registers so the multicycle constraint covers the whole path.
  assign w_product = 64'(r_op_a) * 64'(r_op_b);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)         w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == '0)      w_state_nxt = S_DONE;
      S_DONE:  if (bus.rsp_ready)    w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= LAST_RST;
      r_id         <= '0;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_p      <= '0;
      r_rsp_id     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_id         <= w_win_idx;
            r_last_grant <= w_win_idx;
            r_cnt        <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_p     <= w_product;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_p     = r_rsp_p;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul32_share_arb.sv
// Directed bench for mul32_share_arb: vector table of single transactions plus
// hand-written sequences for round robin, backpressure, operand hold and mid-flight reset.
`timescale 1ns/1ps
module tb_mul32_share_arb;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul32_share_arb_if #(.NREQ(NREQ), .ID_W(ID_W)) bus_if ();

  mul32_share_arb #(.NREQ(NREQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [31:0] a_arr [NREQ];
  logic [31:0] b_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus_if.req_a[32*i +: 32] = a_arr[i];
      bus_if.req_b[32*i +: 32] = b_arr[i];
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs [5];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the combinational grant in IDLE, then takes the accept edge.
  task automatic accept(input int id);
    check("req_ready_grant", 64'(bus_if.req_ready), 64'(1) << id);
    step();
    check("busy_after_accept", 64'(bus_if.busy), 64'd1);
    check("req_ready_busy", 64'(bus_if.req_ready), 64'd0);
  endtask

  // Called right after the accept edge; counts edges until rsp_valid rises.
  task automatic wait_rsp(input int id, input logic [63:0] p);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus_if.rsp_valid) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: rsp_valid not seen in 20 cycles, required after %0d", MUL_LAT);
    end else begin
      check("rsp_latency", 64'(lat), 64'(MUL_LAT));
      check("rsp_p", bus_if.rsp_p, p);
      check("rsp_id", 64'(bus_if.rsp_id), 64'(id));
      check("busy_done", 64'(bus_if.busy), 64'd1);
    end
  endtask

  task automatic finish_rsp();
    bus_if.rsp_ready = 1'b1;
    step();
    check("rsp_valid_cleared", 64'(bus_if.rsp_valid), 64'd0);
    check("busy_idle", 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{id: 2, a: 32'h0000_0003, b: 32'h0000_0005, p: 64'h0000_0000_0000_000F};
    vecs[1] = '{id: 0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, p: 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{id: 1, a: 32'h0000_0000, b: 32'hFFFF_FFFF, p: 64'h0000_0000_0000_0000};
    vecs[3] = '{id: 3, a: 32'h0001_0000, b: 32'h0001_0000, p: 64'h0000_0001_0000_0000};
    vecs[4] = '{id: 0, a: 32'hFFFF_FFFF, b: 32'h0000_0002, p: 64'h0000_0001_FFFF_FFFE};

    // Reset with all requesters already valid.
    rst              = 1'b1;
    bus_if.req_valid = '1;
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'(i + 1);
      b_arr[i] = 32'd10;
    end
    step();
    check("req_ready_in_reset", 64'(bus_if.req_ready), 64'd0);
    step();
    check("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    check("rst_rsp_p", bus_if.rsp_p, 64'd0);
    check("rst_rsp_id", 64'(bus_if.rsp_id), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    rst = 1'b0;
    #1;

    // All four continuously valid: grants 0,1,2,3,0.
    for (int n = 0; n < 5; n++) begin
      accept(n % NREQ);
      wait_rsp(n % NREQ, 64'(((n % NREQ) + 1) * 10));
      finish_rsp();
    end
    bus_if.req_valid = '0;

    // Table of single-requester transactions.
    for (int v = 0; v < 5; v++) begin
      a_arr[vecs[v].id] = vecs[v].a;
      b_arr[vecs[v].id] = vecs[v].b;
      bus_if.req_valid  = NREQ'(1) << vecs[v].id;
      #1;
      accept(vecs[v].id);
      bus_if.req_valid = '0;
      wait_rsp(vecs[v].id, vecs[v].p);
      finish_rsp();
    end

    // Backpressure: response held for 5 cycles, requester 0 waiting meanwhile.
    a_arr[1] = 32'd6;
    b_arr[1] = 32'd7;
    bus_if.rsp_ready = 1'b0;
    bus_if.req_valid = 4'b0010;
    #1;
    accept(1);
    bus_if.req_valid = 4'b0001;
    a_arr[0] = 32'd2;
    b_arr[0] = 32'd3;
    wait_rsp(1, 64'd42);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
      check("bp_rsp_p", bus_if.rsp_p, 64'd42);
      check("bp_rsp_id", 64'(bus_if.rsp_id), 64'd1);
      check("bp_busy", 64'(bus_if.busy), 64'd1);
      check("bp_req_ready", 64'(bus_if.req_ready), 64'd0);
    end
    finish_rsp();
    check("bp_rsp_p_held", bus_if.rsp_p, 64'd42);
    check("bp_rsp_id_held", 64'(bus_if.rsp_id), 64'd1);
    accept(0);
    bus_if.req_valid = '0;
    wait_rsp(0, 64'd6);
    finish_rsp();

    // Operand change after accept must not affect the product.
    a_arr[0] = 32'd7;
    b_arr[0] = 32'd3;
    bus_if.req_valid = 4'b0001;
    #1;
    accept(0);
    bus_if.req_valid = '0;
    a_arr[0] = 32'd9;
    wait_rsp(0, 64'd21);
    finish_rsp();

    // Reset one cycle after accept: transaction discarded, priority back to requester 0.
    a_arr[2] = 32'd5;
    b_arr[2] = 32'd5;
    bus_if.req_valid = 4'b0100;
    #1;
    accept(2);
    bus_if.req_valid = '0;
    rst = 1'b1;
    step();
    check("midrst_busy", 64'(bus_if.busy), 64'd0);
    check("midrst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    a_arr[1] = 32'd11;
    b_arr[1] = 32'd2;
    a_arr[3] = 32'd4;
    b_arr[3] = 32'd4;
    bus_if.req_valid = 4'b1010;
    #1;
    check("midrst_req_ready_in_reset", 64'(bus_if.req_ready), 64'd0);
    rst = 1'b0;
    #1;
    accept(1);
    wait_rsp(1, 64'd22);
    finish_rsp();
    accept(3);
    bus_if.req_valid = '0;
    wait_rsp(3, 64'd16);
    finish_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
